// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared types and constants for the iterative RV32M divider
package alu_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_e;

    localparam int unsigned DIV_ITERS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/alu_div_step.sv
// alu_div_step: one restoring shift-subtract iteration producing a quotient bit
module alu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] r_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] r_o,
    output logic         q_bit_o
);

    logic [W:0]   rs;
    logic [W-1:0] diff;

    // the shifted remainder is always below twice the divisor, so the
    // difference fits in W bits whenever the subtraction is taken
    assign rs      = {r_i, q_msb_i};
    assign diff    = rs[W-1:0] - divisor_i;
    assign q_bit_o = rs >= {1'b0, divisor_i};
    assign r_o     = q_bit_o ? diff : rs[W-1:0];

endmodule

// File: rtl/alu_iter_divider.sv
// alu_iter_divider: iterative signed/unsigned divide and remainder, one quotient bit per clock
module alu_iter_divider
    import alu_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result
);

    div_state_e        state_q, state_d;
    div_op_e           op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d, res_q, res_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              nq_q, nq_d, nr_q, nr_d;
    logic [DATA_W-1:0] step_r, abs_a, abs_b, sel;
    logic              step_bit, sgn, is_rem, ovf;

    assign sgn    = ~op_q[0];
    assign is_rem = op_q[1];
    assign abs_a  = (sgn && a_q[DATA_W-1]) ? -a_q : a_q;
    assign abs_b  = (sgn && b_q[DATA_W-1]) ? -b_q : b_q;
    assign ovf    = sgn && a_q == INT_MIN && b_q == DIV_ZERO_Q;
    assign sel    = is_rem ? r_q : q_q;

    alu_div_step #(.W(DATA_W)) u_step (
        .r_i      (r_q),
        .q_msb_i  (q_q[DATA_W-1]),
        .divisor_i(b_q),
        .r_o      (step_r),
        .q_bit_o  (step_bit)
    );

    // next-state and datapath updates for the IDLE/PREP/CALC/FIX/DONE sequence
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = PREP;
                op_d    = div_op_e'(i_op);
                a_d     = i_a;
                b_d     = i_b;
            end
            PREP: begin
                nq_d  = sgn & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                nr_d  = sgn & a_q[DATA_W-1];
                r_d   = '0;
                q_d   = abs_a;
                b_d   = abs_b;
                cnt_d = '0;
                if (b_q == '0) begin
                    res_d   = is_rem ? a_q : DIV_ZERO_Q;
                    state_d = DONE;
                end else if (ovf) begin
                    res_d   = is_rem ? '0 : INT_MIN;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d     = step_r;
                q_d     = {q_q[DATA_W-2:0], step_bit};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'(DIV_ITERS - 1)) ? FIX : CALC;
            end
            FIX: begin
                res_d   = (is_rem ? nr_q : nq_q) ? -sel : sel;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            op_q    <= DIV;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            res_q   <= res_d;
        end
    end

    assign o_busy   = state_q != IDLE;
    assign o_valid  = state_q == DONE;
    assign o_result = res_q;

endmodule

// File: tb/tb_alu_iter_divider.sv
// tb_alu_iter_divider: randomized and directed checks of the iterative divider against an arithmetic model
module tb_alu_iter_divider;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'd0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        o_busy, o_valid;
    logic [31:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iter_divider dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return 32'(sa / sb);
            2'd1:    return a / b;
            2'd2:    return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit after_ok);
        i_op = op;
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op = 2'($urandom);
        i_a = $urandom;
        i_b = $urandom;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        res = o_result;
        @(posedge i_clk);
        #1;
        after_ok = !o_valid && !o_busy && o_result == res;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        n_tests++;
        if ({o_busy, o_valid, o_result} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b result=%h, required 0/0/0", o_busy, o_valid, o_result);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [9] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3};
        logic [31:0] as  [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFB,
                                 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                 32'h8000_0000, 32'd0, 32'd5};
        int          lats[9] = '{34, 34, 34, 34, 1, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        bit          ok;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, ok);
            n_tests++;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, exp[i]);
            end
            n_tests++;
            if (lat != lats[i]) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, lats[i]);
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL directed_pulse[%0d]: valid/busy not low or result not held after done", i);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        bit          ok;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(op, a, b, res, lat, ok);
            n_tests++;
            if (res !== ref_result(op, a, b) || lat != ref_lat(op, a, b) || !ok) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, op, a, b, res, lat, ref_result(op, a, b), ref_lat(op, a, b));
            end
        end
    endtask

    task automatic test_ignore_start();
        bit seen = 1'b0;
        i_op = 2'd1;
        i_a = 32'd100;
        i_b = 32'd7;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_op = 2'd1;
        i_a = 32'd1;
        i_b = 32'd1;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_a = 32'hDEAD_BEEF;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(posedge i_clk);
            #1;
            seen = o_valid;
        end
        n_tests++;
        if (!seen || o_result !== 32'd14) begin
            n_fail++;
            $display("FAIL ignore_start: seen=%b result=%h, required 1 and 0000000e", seen, o_result);
        end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge i_clk);
            #1;
            seen |= o_valid | o_busy;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL ignore_not_queued: activity=%b after first result, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          ok, seen = 1'b0;
        i_op = 2'd0;
        i_a = 32'd12345;
        i_b = 32'd11;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (19) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        n_tests++;
        if ({o_busy, o_valid, o_result} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%h, required 0/0/0", o_busy, o_valid, o_result);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge i_clk);
            #1;
            seen |= o_valid;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_no_valid: valid seen=%b after abort, required 0", seen);
        end
        run_op(2'd3, 32'd1000, 32'd33, res, lat, ok);
        n_tests++;
        if (res !== 32'd10 || lat != 34 || !ok) begin
            n_fail++;
            $display("FAIL reset_restart: got %h lat %0d, required 0000000a lat 34", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res;
        int          lat;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            run_op(2'(i), a, b, res, lat, ok);
            n_tests++;
            if (res !== ref_result(2'(i), a, b) || lat != 34 || !ok) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] a=%h b=%h: got %h lat %0d, required %h lat 34",
                         i, a, b, res, lat, ref_result(2'(i), a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
